// File: rtl/nfu_pkg.sv
// Shared constants, FSM state type and saturation helper for the NFU-2 stage.
package nfu_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int Tn        = 16;
  localparam int TnxTn     = Tn * Tn;
  localparam int LOG2_TN   = $clog2(Tn);
  localparam int ACC_WIDTH = 32;
  localparam int CNT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Clamp a wide signed accumulator to the signed BIT_WIDTH range.
  function automatic logic [BIT_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH-1:0] value);
    logic [ACC_WIDTH-BIT_WIDTH:0] upper;
    upper = value[ACC_WIDTH-1:BIT_WIDTH-1];
    if (upper == '0 || upper == '1)
      return value[BIT_WIDTH-1:0];
    else if (value[ACC_WIDTH-1])
      return {1'b1, {(BIT_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(BIT_WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/nfu_2_adder_tree.sv
// One neuron's Tn-input pipelined adder tree; valid/first/last ride alongside the data.
module nfu_2_adder_tree
  import nfu_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [Tn-1:0][BIT_WIDTH-1:0]   in_data,
  output logic                           out_valid,
  output logic                           out_first,
  output logic                           out_last,
  output logic [ACC_WIDTH-1:0]           out_sum
);

  localparam int INNER = Tn - 1;
  localparam int NODES = 2 * Tn - 1;

  // Heap layout: node n has children 2n+1 and 2n+2; indices >= INNER are the leaves.
  logic [ACC_WIDTH-1:0] node_reg [INNER];
  logic [ACC_WIDTH-1:0] node_val [NODES];
  logic [LOG2_TN-1:0]   valid_reg;
  logic [LOG2_TN-1:0]   first_reg;
  logic [LOG2_TN-1:0]   last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NODES; gi++) begin : g_node
      if (gi < INNER) begin : g_inner
        assign node_val[gi] = node_reg[gi];
      end else begin : g_leaf
        assign node_val[gi] = {{(ACC_WIDTH-BIT_WIDTH){in_data[gi-INNER][BIT_WIDTH-1]}},
                               in_data[gi-INNER]};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < INNER; n++) node_reg[n] <= '0;
      valid_reg <= '0;
      first_reg <= '0;
      last_reg  <= '0;
    end else if (en) begin
      for (int n = 0; n < INNER; n++) node_reg[n] <= node_val[2*n+1] + node_val[2*n+2];
      valid_reg <= (valid_reg << 1) | LOG2_TN'(in_valid);
      first_reg <= (first_reg << 1) | LOG2_TN'(in_valid & in_first);
      last_reg  <= (last_reg << 1)  | LOG2_TN'(in_valid & in_last);
    end
  end

  assign out_valid = valid_reg[LOG2_TN-1];
  assign out_first = first_reg[LOG2_TN-1];
  assign out_last  = last_reg[LOG2_TN-1];
  assign out_sum   = node_reg[0];

endmodule

// File: rtl/nfu_2_acc.sv
// NFU-2: per-neuron adder trees feeding a tile accumulator with saturated, handshaked output.
module nfu_2_acc
  import nfu_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           i_ready,
  input  logic                           i_first,
  input  logic                           i_last,
  input  logic [BIT_WIDTH*TnxTn-1:0]     i_products,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [BIT_WIDTH*Tn-1:0]        o_sums,
  output logic [CNT_WIDTH-1:0]           o_tile_cnt,
  output logic                           o_seq_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic en;
  logic accept;
  logic [Tn-1:0]                 lane_valid;
  logic [Tn-1:0]                 lane_first;
  logic [Tn-1:0]                 lane_last;
  logic [Tn-1:0][ACC_WIDTH-1:0]  tsum;
  logic                          t_valid;
  logic                          t_first;
  logic                          t_last;

  state_t                        state_reg, state_next;
  logic [Tn-1:0][ACC_WIDTH-1:0]  acc_reg, acc_next;
  logic [CNT_WIDTH-1:0]          cnt_reg, cnt_next;
  logic [BIT_WIDTH*Tn-1:0]       sums_reg, sums_next;
  logic [CNT_WIDTH-1:0]          tile_cnt_reg, tile_cnt_next;
  logic                          valid_reg, valid_next;
  logic                          seq_err_reg, seq_err_next;

  assign en      = ~valid_reg | o_ready;
  assign i_ready = en;
  assign accept  = i_valid & en;

  genvar gi, gk;
  generate
    for (gi = 0; gi < Tn; gi++) begin : g_neuron
      logic [Tn-1:0][BIT_WIDTH-1:0] column;
      for (gk = 0; gk < Tn; gk++) begin : g_col
        assign column[gk] = i_products[(gk*Tn+gi)*BIT_WIDTH +: BIT_WIDTH];
      end
      nfu_2_adder_tree u_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (accept),
        .in_first  (i_first),
        .in_last   (i_last),
        .in_data   (column),
        .out_valid (lane_valid[gi]),
        .out_first (lane_first[gi]),
        .out_last  (lane_last[gi]),
        .out_sum   (tsum[gi])
      );
    end
  endgenerate

  // Every lane carries identical flags; lane 0 is the reference copy.
  assign t_valid = lane_valid[0];
  assign t_first = lane_first[0];
  assign t_last  = lane_last[0];

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    sums_next     = sums_reg;
    tile_cnt_next = tile_cnt_reg;
    valid_next    = valid_reg;
    seq_err_next  = seq_err_reg;

    if (valid_reg && o_ready) valid_next = 1'b0;

    if (en && t_valid) begin
      if (state_reg == IDLE || t_first) begin
        // A fresh sum; a missing first in IDLE or an early first in ACCUM is a framing error.
        if (state_reg == IDLE && !t_first) seq_err_next = 1'b1;
        if (state_reg == ACCUM && t_first) seq_err_next = 1'b1;
        acc_next = tsum;
        cnt_next = CNT_WIDTH'(1);
      end else begin
        for (int j = 0; j < Tn; j++) acc_next[j] = acc_reg[j] + tsum[j];
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);
      end

      state_next = t_last ? IDLE : ACCUM;

      if (t_last) begin
        for (int j = 0; j < Tn; j++) sums_next[j*BIT_WIDTH +: BIT_WIDTH] = sat_acc(acc_next[j]);
        tile_cnt_next = cnt_next;
        valid_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      sums_reg     <= '0;
      tile_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      sums_reg     <= sums_next;
      tile_cnt_reg <= tile_cnt_next;
      valid_reg    <= valid_next;
      seq_err_reg  <= seq_err_next;
    end
  end

  assign o_valid    = valid_reg;
  assign o_sums     = sums_reg;
  assign o_tile_cnt = tile_cnt_reg;
  assign o_seq_err  = seq_err_reg;

endmodule
